// File: rtl/sonic_v1_15_eth_10g_mac_tx_frame_decoder.sv
// TX frame decoder: passes the 64b Avalon-ST stream through with one cycle of latency and
// emits one status pulse per frame (length, L2 header class, pad/oversize/malformed/error flags).
module sonic_v1_15_eth_10g_mac_tx_frame_decoder #(
    parameter int MIN_FRAME_LEN = 60,
    parameter int MAX_FRAME_LEN = 1514
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [63:0] in_data,
    input  logic [2:0]  in_error,
    input  logic        in_startofpacket,
    input  logic        in_endofpacket,
    input  logic [2:0]  in_empty,
    output logic        out_valid,
    output logic [63:0] out_data,
    output logic [2:0]  out_error,
    output logic        out_startofpacket,
    output logic        out_endofpacket,
    output logic [2:0]  out_empty,
    output logic        stat_valid,
    output logic [15:0] stat_length,
    output logic [15:0] stat_type_len,
    output logic        stat_broadcast,
    output logic        stat_multicast,
    output logic        stat_vlan,
    output logic        stat_svlan,
    output logic        stat_pad_needed,
    output logic        stat_oversize,
    output logic        stat_malformed,
    output logic        stat_error
);

    typedef enum logic [2:0] {S_IDLE, S_HDR1, S_TAG, S_SVLAN, S_BODY} state_t;

    typedef struct packed {
        logic [15:0] len;
        logic [15:0] type_len;
        logic        hdr_ok;
        logic        bcast;
        logic        mcast;
        logic        vlan;
        logic        svlan;
        logic        err;
    } frame_t;

    localparam logic [15:0] TPID_VLAN  = 16'h8100;
    localparam logic [15:0] TPID_SVLAN = 16'h88A8;

    state_t      state_q, state_d;
    frame_t      frame_q, frame_d;
    frame_t      rpt;
    logic        fire, drop, rpt_malformed, rpt_pad, rpt_over;
    logic [3:0]  beat_bytes;
    logic [15:0] lead_word, mid_word;
    logic [1:0]  tags;
    logic [16:0] max_len;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d       = state_q;
        frame_d       = frame_q;
        rpt           = '0;
        fire          = 1'b0;
        drop          = 1'b0;
        rpt_malformed = 1'b0;
        beat_bytes    = in_endofpacket ? (4'd8 - {1'b0, in_empty}) : 4'd8;
        lead_word     = in_data[63:48];
        mid_word      = in_data[31:16];

        if (in_valid) begin
            if (in_startofpacket) begin
                // An open frame is closed out as malformed; a new SOP+EOP beat in that same
                // cycle loses its own status since only one pulse fits per cycle.
                if (state_q != S_IDLE) begin
                    fire          = 1'b1;
                    rpt           = frame_q;
                    rpt_malformed = 1'b1;
                end
                frame_d       = '0;
                frame_d.len   = {12'd0, beat_bytes};
                frame_d.err   = |in_error;
                frame_d.bcast = (&in_data[63:16]) && (beat_bytes >= 4'd6);
                frame_d.mcast = in_data[56] && !frame_d.bcast;
                if (!in_endofpacket) begin
                    state_d = S_HDR1;
                end else begin
                    state_d = S_IDLE;
                    if (state_q == S_IDLE) begin
                        fire          = 1'b1;
                        rpt           = frame_d;
                        rpt_malformed = 1'b1;
                    end
                end
            end else if (state_q == S_IDLE) begin
                drop          = 1'b1;
                fire          = 1'b1;
                rpt_malformed = 1'b1;
                rpt.err       = |in_error;
            end else begin
                frame_d.len = sat_add(frame_q.len, beat_bytes);
                frame_d.err = frame_q.err | (|in_error);
                state_d     = S_BODY;
                case (state_q)
                    S_HDR1: begin
                        if (beat_bytes >= 4'd6) begin
                            if (mid_word == TPID_VLAN) begin
                                frame_d.vlan = 1'b1;
                                state_d      = S_TAG;
                            end else if (mid_word == TPID_SVLAN) begin
                                state_d = S_SVLAN;
                            end else begin
                                frame_d.type_len = mid_word;
                                frame_d.hdr_ok   = 1'b1;
                            end
                        end
                    end
                    S_TAG: begin
                        if (beat_bytes >= 4'd2) begin
                            frame_d.type_len = lead_word;
                            frame_d.hdr_ok   = 1'b1;
                        end
                    end
                    S_SVLAN: begin
                        // Without an inner 0x8100 the frame is treated as untagged, type 0x88A8.
                        if (beat_bytes >= 4'd2) begin
                            if (lead_word != TPID_VLAN) begin
                                frame_d.type_len = TPID_SVLAN;
                                frame_d.hdr_ok   = 1'b1;
                            end else if (beat_bytes >= 4'd6) begin
                                frame_d.svlan    = 1'b1;
                                frame_d.type_len = mid_word;
                                frame_d.hdr_ok   = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
                if (in_endofpacket) begin
                    fire          = 1'b1;
                    rpt           = frame_d;
                    rpt_malformed = !frame_d.hdr_ok;
                    state_d       = S_IDLE;
                end
            end
        end

        // Header fields are only meaningful once the type/len bytes were seen.
        if (!rpt.hdr_ok) begin
            rpt.type_len = '0;
            rpt.vlan     = 1'b0;
            rpt.svlan    = 1'b0;
        end
        tags     = rpt.svlan ? 2'd2 : (rpt.vlan ? 2'd1 : 2'd0);
        max_len  = 17'(MAX_FRAME_LEN) + {13'd0, tags, 2'b00};
        rpt_pad  = rpt.len < 16'(MIN_FRAME_LEN);
        rpt_over = {1'b0, rpt.len} > max_len;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            frame_q <= '0;
        end else if (in_valid) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            frame_q <= frame_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid         <= 1'b0;
            out_data          <= '0;
            out_error         <= '0;
            out_startofpacket <= 1'b0;
            out_endofpacket   <= 1'b0;
            out_empty         <= '0;
            stat_valid        <= 1'b0;
            stat_length       <= '0;
            stat_type_len     <= '0;
            stat_broadcast    <= 1'b0;
            stat_multicast    <= 1'b0;
            stat_vlan         <= 1'b0;
            stat_svlan        <= 1'b0;
            stat_pad_needed   <= 1'b0;
            stat_oversize     <= 1'b0;
            stat_malformed    <= 1'b0;
            stat_error        <= 1'b0;
        end else begin
            out_valid         <= in_valid && !drop;
            out_data          <= in_data;
            out_error         <= in_error;
            out_startofpacket <= in_startofpacket;
            out_endofpacket   <= in_endofpacket;
            out_empty         <= in_empty;
            stat_valid        <= fire;
            if (fire) begin
                stat_length     <= rpt.len;
                stat_type_len   <= rpt.type_len;
                stat_broadcast  <= rpt.bcast;
                stat_multicast  <= rpt.mcast;
                stat_vlan       <= rpt.vlan;
                stat_svlan      <= rpt.svlan;
                stat_pad_needed <= rpt_pad;
                stat_oversize   <= rpt_over;
                stat_malformed  <= rpt_malformed;
                stat_error      <= rpt.err;
            end
        end
    end

endmodule

// File: tb/tb_sonic_v1_15_eth_10g_mac_tx_frame_decoder.sv
// Bench for the TX frame decoder: byte-level frame model checked every cycle, plus
// directed frames with hand-computed status expectations.
module tb_sonic_v1_15_eth_10g_mac_tx_frame_decoder;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
        logic [2:0]  error;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
    } out_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] len;
        logic [15:0] tl;
        logic        bc, mc, vl, sv, pad, over, malf, err;
    } stat_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic [2:0]  in_error = '0;
    logic        in_startofpacket = 1'b0;
    logic        in_endofpacket = 1'b0;
    logic [2:0]  in_empty = '0;
    logic        out_valid, out_startofpacket, out_endofpacket;
    logic [63:0] out_data;
    logic [2:0]  out_error, out_empty;
    logic        stat_valid, stat_broadcast, stat_multicast, stat_vlan, stat_svlan;
    logic        stat_pad_needed, stat_oversize, stat_malformed, stat_error;
    logic [15:0] stat_length, stat_type_len;

    sonic_v1_15_eth_10g_mac_tx_frame_decoder dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_error(in_error),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket), .in_empty(in_empty),
        .out_valid(out_valid), .out_data(out_data), .out_error(out_error),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
        .stat_valid(stat_valid), .stat_length(stat_length), .stat_type_len(stat_type_len),
        .stat_broadcast(stat_broadcast), .stat_multicast(stat_multicast),
        .stat_vlan(stat_vlan), .stat_svlan(stat_svlan), .stat_pad_needed(stat_pad_needed),
        .stat_oversize(stat_oversize), .stat_malformed(stat_malformed), .stat_error(stat_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: frames as byte arrays ----------------
    logic [7:0] mbytes[$];
    bit         m_open = 1'b0;
    bit         m_err  = 1'b0;
    out_t       exp_out = '0;
    stat_t      exp_stat = '0;

    function automatic logic [15:0] word_at(input int k);
        return {mbytes[k], mbytes[k+1]};
    endfunction

    task automatic take_beat();
        int n;
        n = in_endofpacket ? 8 - int'(in_empty) : 8;
        for (int k = 0; k < n; k++) mbytes.push_back(in_data[63-8*k -: 8]);
    endtask

    task automatic report(input bit missing_eop);
        int          n, tags;
        bit          ok;
        logic [15:0] t;
        logic [7:0]  b0;
        n = mbytes.size();
        exp_stat       = '0;
        exp_stat.valid = 1'b1;
        exp_stat.len   = (n > 65535) ? 16'hFFFF : 16'(n);
        exp_stat.bc    = (n >= 6);
        for (int i = 0; i < 6; i++) if (i < n && mbytes[i] != 8'hFF) exp_stat.bc = 1'b0;
        b0 = (n > 0) ? mbytes[0] : 8'h00;
        exp_stat.mc = b0[0] && !exp_stat.bc;
        ok = 1'b0;
        if (n >= 14) begin
            t = word_at(12);
            if (t == 16'h8100) begin
                if (n >= 18) begin ok = 1'b1; exp_stat.vl = 1'b1; exp_stat.tl = word_at(16); end
            end else if (t == 16'h88A8) begin
                if (n >= 18) begin
                    if (word_at(16) != 16'h8100) begin
                        ok = 1'b1; exp_stat.tl = 16'h88A8;
                    end else if (n >= 22) begin
                        ok = 1'b1; exp_stat.sv = 1'b1; exp_stat.tl = word_at(20);
                    end
                end
            end else begin
                ok = 1'b1; exp_stat.tl = t;
            end
        end
        tags          = exp_stat.sv ? 2 : (exp_stat.vl ? 1 : 0);
        exp_stat.pad  = (n < 60);
        exp_stat.over = (n > 1514 + 4 * tags);
        exp_stat.malf = missing_eop || !ok;
        exp_stat.err  = m_err;
    endtask

    always @(posedge clk or negedge reset_n) begin : model
        bit reported;
        if (!reset_n) begin
            exp_out  = '0;
            exp_stat = '0;
            mbytes.delete();
            m_open   = 1'b0;
            m_err    = 1'b0;
        end else begin
            exp_out        = {in_valid, in_data, in_error, in_startofpacket, in_endofpacket, in_empty};
            exp_stat.valid = 1'b0;
            reported       = 1'b0;
            if (in_valid) begin
                if (in_startofpacket) begin
                    if (m_open) begin report(1'b1); reported = 1'b1; end
                    mbytes.delete();
                    m_err  = |in_error;
                    m_open = 1'b1;
                    take_beat();
                    if (in_endofpacket) begin
                        m_open = 1'b0;
                        if (!reported) report(1'b1);
                    end
                end else if (!m_open) begin
                    exp_out.valid = 1'b0;
                    exp_stat      = '0;
                    exp_stat.valid = 1'b1;
                    exp_stat.pad  = 1'b1;
                    exp_stat.malf = 1'b1;
                    exp_stat.err  = |in_error;
                end else begin
                    m_err = m_err | (|in_error);
                    take_beat();
                    if (in_endofpacket) begin m_open = 1'b0; report(1'b0); end
                end
            end
        end
    end

    // ---------------- compare process ----------------
    out_t  act_out;
    stat_t act_stat;
    stat_t pulse_log[$];
    bit    cmp_en = 1'b0;

    assign act_out  = {out_valid, out_data, out_error, out_startofpacket, out_endofpacket, out_empty};
    assign act_stat = {stat_valid, stat_length, stat_type_len, stat_broadcast, stat_multicast,
                       stat_vlan, stat_svlan, stat_pad_needed, stat_oversize, stat_malformed, stat_error};

    always @(negedge clk) begin
        if (cmp_en) begin
            check("out_stream", 128'(act_out), 128'(exp_out));
            check("stat_fields", 128'(act_stat), 128'(exp_stat));
            if (stat_valid) pulse_log.push_back(act_stat);
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] fb[$];

    task automatic quiet();
        in_valid = 1'b0; in_data = '0; in_error = '0;
        in_startofpacket = 1'b0; in_endofpacket = 1'b0; in_empty = '0;
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic s, input logic e,
                         input logic [2:0] emp, input logic [2:0] err);
        in_valid = v; in_data = d; in_startofpacket = s; in_endofpacket = e;
        in_empty = emp; in_error = err;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        quiet();
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic hdr(input logic [47:0] da);
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(da[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(8'hA0 + 8'(i));
    endtask

    task automatic push16(input logic [15:0] w);
        fb.push_back(w[15:8]);
        fb.push_back(w[7:0]);
    endtask

    task automatic fill_to(input int total);
        while (fb.size() < total) fb.push_back(8'(fb.size() * 7 + 3));
    endtask

    task automatic send_fb(input bit with_eop, input int gap_after, input logic [2:0] eop_err);
        int n, nb, cnt;
        bit last;
        logic [63:0] d;
        n  = fb.size();
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = '0;
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < n) begin d[63-8*k -: 8] = fb[b*8+k]; cnt++; end
            end
            last = (b == nb - 1);
            drive(1'b1, d, b == 0, last && with_eop,
                  (last && with_eop) ? 3'(8 - cnt) : 3'd0, last ? eop_err : 3'd0);
            if (b == gap_after && !last) idle(2);
        end
        quiet();
    endtask

    initial begin : timeout
        #300000;
        $display("FAIL timeout: bench still running (required: finished)");
        $fatal(1);
    end

    initial begin : main
        int    n0;
        stat_t p;

        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_stat_valid", stat_valid, 0);
        check("rst_stat_length", stat_length, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        idle(2);

        // 64B broadcast untagged, 60 bytes excl. FCS, gap mid-frame
        n0 = pulse_log.size();
        hdr(48'hFFFF_FFFF_FFFF); push16(16'h0800); fill_to(60);
        send_fb(1'b1, 2, 3'd0);
        idle(3);
        check("a_pulses", pulse_log.size(), n0 + 1);
        p = pulse_log[n0];
        check("a_length", p.len, 60);
        check("a_broadcast", p.bc, 1);
        check("a_type_len", p.tl, 16'h0800);
        check("a_pad", p.pad, 0);
        check("a_malformed", p.malf, 0);

        // VLAN frames at and just above the tagged limit
        n0 = pulse_log.size();
        hdr(48'h0011_2233_4455); push16(16'h8100); push16(16'h0003); push16(16'h86DD); fill_to(1518);
        send_fb(1'b1, -1, 3'd0);
        hdr(48'h0011_2233_4455); push16(16'h8100); push16(16'h0003); push16(16'h86DD); fill_to(1519);
        send_fb(1'b1, 100, 3'd0);
        idle(3);
        check("vlan_pulses", pulse_log.size(), n0 + 2);
        p = pulse_log[n0];
        check("vlan1518_length", p.len, 1518);
        check("vlan1518_vlan", p.vl, 1);
        check("vlan1518_type", p.tl, 16'h86DD);
        check("vlan1518_oversize", p.over, 0);
        p = pulse_log[n0+1];
        check("vlan1519_oversize", p.over, 1);

        // S-VLAN 42B multicast, error on EOP beat
        n0 = pulse_log.size();
        hdr(48'h0100_5E00_0001); push16(16'h88A8); push16(16'h0005);
        push16(16'h8100); push16(16'h0064); push16(16'h0806); fill_to(42);
        send_fb(1'b1, -1, 3'b010);
        idle(3);
        check("svlan_pulses", pulse_log.size(), n0 + 1);
        p = pulse_log[n0];
        check("svlan_svlan", p.sv, 1);
        check("svlan_vlan", p.vl, 0);
        check("svlan_multicast", p.mc, 1);
        check("svlan_pad", p.pad, 1);
        check("svlan_type", p.tl, 16'h0806);
        check("svlan_error", p.err, 1);

        // Missing EOP: 3 beats, then a new SOP frame
        n0 = pulse_log.size();
        hdr(48'h0200_0000_0001); push16(16'h0800); fill_to(24);
        send_fb(1'b0, -1, 3'd0);
        idle(1);
        hdr(48'hFFFF_FFFF_FFFF); push16(16'h0800); fill_to(60);
        send_fb(1'b1, -1, 3'd0);
        idle(3);
        check("miss_pulses", pulse_log.size(), n0 + 2);
        p = pulse_log[n0];
        check("miss_malformed", p.malf, 1);
        check("miss_length", p.len, 24);
        p = pulse_log[n0+1];
        check("after_miss_malformed", p.malf, 0);
        check("after_miss_length", p.len, 60);

        // Stray non-SOP beat is dropped
        n0 = pulse_log.size();
        drive(1'b1, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0, 3'd0, 3'b001);
        quiet();
        @(negedge clk);
        check("stray_out_valid", out_valid, 0);
        idle(2);
        check("stray_pulses", pulse_log.size(), n0 + 1);
        p = pulse_log[n0];
        check("stray_malformed", p.malf, 1);
        check("stray_length", p.len, 0);

        // Single-beat SOP+EOP, empty=2
        n0 = pulse_log.size();
        hdr(48'h0A0B_0C0D_0E0F);
        while (fb.size() > 6) void'(fb.pop_back());
        send_fb(1'b1, -1, 3'd0);
        idle(3);
        check("single_pulses", pulse_log.size(), n0 + 1);
        p = pulse_log[n0];
        check("single_length", p.len, 6);
        check("single_malformed", p.malf, 1);
        check("single_type", p.tl, 0);

        // Reset mid-frame, then a clean frame
        n0 = pulse_log.size();
        hdr(48'h00AA_BBCC_DDEE); push16(16'h0800); fill_to(24);
        send_fb(1'b0, -1, 3'd0);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_stat_length", stat_length, 0);
        check("midrst_out_data", out_data, 0);
        @(posedge clk); #2 reset_n = 1'b1;
        idle(1);
        hdr(48'h00AA_BBCC_DDEE); push16(16'h0806); fill_to(64);
        send_fb(1'b1, -1, 3'd0);
        idle(3);
        check("postrst_pulses", pulse_log.size(), n0 + 1);
        p = pulse_log[n0];
        check("postrst_length", p.len, 64);
        check("postrst_malformed", p.malf, 0);
        check("postrst_type", p.tl, 16'h0806);
        check("postrst_broadcast", p.bc, 0);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
